// File: rtl/rv_pkg.sv
// Shared write-back types: data/address widths and the
// write-source tag used to steer scoreboard clears.
package rv_pkg;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_LD
    } wb_src_e;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } ld_ent_t;
endpackage

// File: rtl/rf_writeback_if.sv
// Bundle between execute/memory/decode and the write-back
// controller; slave is the controller side.
interface rf_writeback_if;
    import rv_pkg::*;

    logic            alu_valid;
    logic [AW-1:0]   alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_stall;
    logic            ld_valid;
    logic            ld_ready;
    logic [AW-1:0]   ld_rd;
    logic [XLEN-1:0] ld_data;
    logic            mark_valid;
    logic [AW-1:0]   mark_rd;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic            rs1_busy;
    logic            rs2_busy;
    logic [NREG-1:0] pend;
    logic            we3;
    logic [AW-1:0]   a3;
    logic [XLEN-1:0] wd3;
    logic            err;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_valid, ld_rd, ld_data,
        output mark_valid, mark_rd, rs1, rs2,
        input  alu_stall, ld_ready, rs1_busy, rs2_busy,
        input  pend, we3, a3, wd3, err
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_valid, ld_rd, ld_data,
        input  mark_valid, mark_rd, rs1, rs2,
        output alu_stall, ld_ready, rs1_busy, rs2_busy,
        output pend, we3, a3, wd3, err
    );
endinterface

// File: rtl/wb_fifo2.sv
// Two-deep {rd, data} buffer for load returns; push and
// pop may coincide whenever the buffer is not full.
module wb_fifo2
    import rv_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  ld_ent_t    din,
    output ld_ent_t    dout,
    output logic       full,
    output logic       empty,
    output logic [1:0] count
);
    ld_ent_t [1:0] mem_q, mem_d;
    logic          wp_q, wp_d;
    logic          rp_q, rp_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full  = (cnt_q == 2'd2);
    assign empty = (cnt_q == 2'd0);
    assign count = cnt_q;
    assign dout  = mem_q[rp_q];

    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        mem_d   = mem_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        if (do_push) begin
            mem_d[wp_q] = din;
            wp_d        = !wp_q;
        end
        if (do_pop) begin
            rp_d = !rp_q;
        end
        cnt_d = cnt_q + 2'(do_push) - 2'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
            wp_q  <= 1'b0;
            rp_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            mem_q <= mem_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/rf_writeback.sv
// Register-file write port: merges ALU and load-return writes,
// bounds load starvation, and tracks pending loads for decode.
module rf_writeback
    import rv_pkg::*;
#(
    parameter int STARVE_MAX = 3
) (
    input logic           clk,
    input logic           rst_n,
    rf_writeback_if.slave bus
);
    localparam int CW = $clog2(STARVE_MAX + 1);

    ld_ent_t         head;
    logic            fifo_full, fifo_empty;
    logic [1:0]      fifo_cnt;
    logic            ld_push, ld_pop, stall;
    wb_src_e         src;
    logic [AW-1:0]   win_rd;
    logic [XLEN-1:0] win_data;

    logic [CW-1:0]   cnt_q, cnt_d;
    logic            we3_q, we3_d;
    logic [AW-1:0]   a3_q, a3_d;
    logic [XLEN-1:0] wd3_q, wd3_d;
    wb_src_e         src_q, src_d;
    logic [NREG-1:0] pend_q, pend_d;
    logic            err_q, err_d;

    assign ld_push = bus.ld_valid && !fifo_full;
    assign stall   = (cnt_q == CW'(STARVE_MAX)) && !fifo_empty;

    wb_fifo2 u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (ld_push),
        .pop   (ld_pop),
        .din   ('{rd: bus.ld_rd, data: bus.ld_data}),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    // A stalled ALU forces the load path even if alu_valid is high.
    always_comb begin
        src      = WB_NONE;
        win_rd   = '0;
        win_data = '0;
        if (stall) begin
            src      = WB_LD;
            win_rd   = head.rd;
            win_data = head.data;
        end else if (bus.alu_valid) begin
            src      = WB_ALU;
            win_rd   = bus.alu_rd;
            win_data = bus.alu_data;
        end else if (!fifo_empty) begin
            src      = WB_LD;
            win_rd   = head.rd;
            win_data = head.data;
        end
    end

    assign ld_pop = (src == WB_LD);

    always_comb begin
        cnt_d = cnt_q;
        if (fifo_empty || ld_pop) begin
            cnt_d = '0;
        end else if (src == WB_ALU && cnt_q != CW'(STARVE_MAX)) begin
            cnt_d = cnt_q + CW'(1);
        end
        we3_d = (src != WB_NONE) && (win_rd != '0);
        a3_d  = we3_d ? win_rd : a3_q;
        wd3_d = we3_d ? win_data : wd3_q;
        src_d = we3_d ? src : WB_NONE;
        err_d = err_q || (bus.alu_valid && stall);
        // Clear before set so a same-edge re-mark survives.
        pend_d = pend_q;
        if (we3_q && src_q == WB_LD) begin
            pend_d[a3_q] = 1'b0;
        end
        if (bus.mark_valid && bus.mark_rd != '0) begin
            pend_d[bus.mark_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            we3_q  <= 1'b0;
            a3_q   <= '0;
            wd3_q  <= '0;
            src_q  <= WB_NONE;
            pend_q <= '0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            we3_q  <= we3_d;
            a3_q   <= a3_d;
            wd3_q  <= wd3_d;
            src_q  <= src_d;
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

    assign bus.ld_ready  = (fifo_cnt != 2'd2);
    assign bus.alu_stall = stall;
    assign bus.rs1_busy  = pend_q[bus.rs1] && (bus.rs1 != '0);
    assign bus.rs2_busy  = pend_q[bus.rs2] && (bus.rs2 != '0);
    assign bus.pend      = pend_q;
    assign bus.we3       = we3_q;
    assign bus.a3        = a3_q;
    assign bus.wd3       = wd3_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_rf_writeback.sv
// Directed vector table plus randomized run against a
// queue-based reference model of the write-back controller.
module tb_rf_writeback;
    import rv_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rf_writeback_if bus ();

    rf_writeback #(.STARVE_MAX(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drv(input logic av, input logic [4:0] ard,
                       input logic [31:0] adat, input logic lv,
                       input logic [4:0] lrd, input logic [31:0] ldat,
                       input logic mv, input logic [4:0] mrd,
                       input logic [4:0] r1, input logic [4:0] r2);
        bus.alu_valid  = av;
        bus.alu_rd     = ard;
        bus.alu_data   = adat;
        bus.ld_valid   = lv;
        bus.ld_rd      = lrd;
        bus.ld_data    = ldat;
        bus.mark_valid = mv;
        bus.mark_rd    = mrd;
        bus.rs1        = r1;
        bus.rs2        = r2;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_we3"}, 32'(bus.we3), 32'd0);
        chk({tag, "_a3"}, 32'(bus.a3), 32'd0);
        chk({tag, "_wd3"}, bus.wd3, 32'd0);
        chk({tag, "_pend"}, bus.pend, 32'd0);
        chk({tag, "_err"}, 32'(bus.err), 32'd0);
        chk({tag, "_ready"}, 32'(bus.ld_ready), 32'd1);
        chk({tag, "_stall"}, 32'(bus.alu_stall), 32'd0);
    endtask

    // Directed vectors: inputs, pre-edge expectations, post-edge expectations.
    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldat;
        logic        mv;
        logic [4:0]  mrd;
        logic [4:0]  r1;
        logic        rdy;
        logic        st;
        logic        busy;
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] pend;
        logic        err;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic av, input logic [4:0] ard,
                       input logic [31:0] adat, input logic lv,
                       input logic [4:0] lrd, input logic [31:0] ldat,
                       input logic mv, input logic [4:0] mrd,
                       input logic [4:0] r1, input logic rdy,
                       input logic st, input logic busy,
                       input logic we, input logic [4:0] a3,
                       input logic [31:0] wd, input logic [31:0] pend,
                       input logic err);
        vec_t v;
        v = '{av, ard, adat, lv, lrd, ldat, mv, mrd, r1,
              rdy, st, busy, we, a3, wd, pend, err};
        tv.push_back(v);
    endtask

    // Reference model: load queue, starve count, pending set.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    int          m_starve;
    logic [31:0] m_pend;
    logic        m_err;
    logic        m_we;
    logic        m_ld;
    logic [4:0]  m_a3;
    logic [31:0] m_wd;

    function automatic logic m_stall();
        return (m_starve == 3) && (mq.size() != 0);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_starve = 0;
        m_pend   = '0;
        m_err    = 1'b0;
        m_we     = 1'b0;
        m_ld     = 1'b0;
        m_a3     = '0;
        m_wd     = '0;
    endtask

    task automatic model_pre();
        logic e1, e2;
        e1 = m_pend[bus.rs1] && (bus.rs1 != 0);
        e2 = m_pend[bus.rs2] && (bus.rs2 != 0);
        chk("rnd_ready", 32'(bus.ld_ready), 32'(mq.size() < 2));
        chk("rnd_stall", 32'(bus.alu_stall), 32'(m_stall()));
        chk("rnd_busy1", 32'(bus.rs1_busy), 32'(e1));
        chk("rnd_busy2", 32'(bus.rs2_busy), 32'(e2));
    endtask

    task automatic model_step();
        int          sz;
        logic        st, have, from_ld;
        ent_t        w;
        logic [31:0] p;
        sz      = mq.size();
        st      = m_stall();
        have    = 1'b0;
        from_ld = 1'b0;
        w       = '{5'd0, 32'd0};
        if (st || (!bus.alu_valid && sz > 0)) begin
            w       = mq.pop_front();
            have    = 1'b1;
            from_ld = 1'b1;
        end else if (bus.alu_valid) begin
            w    = '{bus.alu_rd, bus.alu_data};
            have = 1'b1;
        end
        if (sz == 0 || from_ld)
            m_starve = 0;
        else if (have)
            m_starve = (m_starve < 3) ? m_starve + 1 : 3;
        if (bus.ld_valid && sz < 2)
            mq.push_back('{bus.ld_rd, bus.ld_data});
        if (bus.alu_valid && st)
            m_err = 1'b1;
        p = m_pend;
        if (m_we && m_ld)
            p[m_a3] = 1'b0;
        if (bus.mark_valid && bus.mark_rd != 0)
            p[bus.mark_rd] = 1'b1;
        m_pend = p;
        m_we   = have && (w.rd != 0);
        m_ld   = from_ld;
        if (m_we) begin
            m_a3 = w.rd;
            m_wd = w.d;
        end
    endtask

    task automatic model_post();
        chk("rnd_we3", 32'(bus.we3), 32'(m_we));
        chk("rnd_a3", 32'(bus.a3), 32'(m_a3));
        chk("rnd_wd3", bus.wd3, m_wd);
        chk("rnd_pend", bus.pend, m_pend);
        chk("rnd_err", 32'(bus.err), 32'(m_err));
    endtask

    initial begin
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        #1;
        chk_reset("rst");
        @(negedge clk);
        rst_n = 1'b1;

        //  av rd adat          lv lrd ldat          mv mrd r1 | rdy st bz | we a3 wd            pend       err
        add(1, 5, 32'h12345678, 0, 0,  32'h0,        0, 0,  0,  1, 0, 0,  1, 5,  32'h12345678, 32'h0,     0);
        add(0, 0, 32'h0,        0, 0,  32'h0,        0, 0,  0,  1, 0, 0,  0, 5,  32'h12345678, 32'h0,     0);
        add(0, 0, 32'h0,        0, 0,  32'h0,        1, 7,  7,  1, 0, 0,  0, 5,  32'h12345678, 32'h80,    0);
        add(0, 0, 32'h0,        1, 7,  32'hCAFEF00D, 0, 0,  7,  1, 0, 1,  0, 5,  32'h12345678, 32'h80,    0);
        add(0, 0, 32'h0,        0, 0,  32'h0,        0, 0,  7,  1, 0, 1,  1, 7,  32'hCAFEF00D, 32'h80,    0);
        add(0, 0, 32'h0,        0, 0,  32'h0,        0, 0,  7,  1, 0, 1,  0, 7,  32'hCAFEF00D, 32'h0,     0);
        add(0, 0, 32'h0,        0, 0,  32'h0,        0, 0,  7,  1, 0, 0,  0, 7,  32'hCAFEF00D, 32'h0,     0);
        add(1, 1, 32'h11,       1, 10, 32'hA0A0,     0, 0,  0,  1, 0, 0,  1, 1,  32'h11,       32'h0,     0);
        add(1, 2, 32'h22,       1, 11, 32'hB0B0,     0, 0,  0,  1, 0, 0,  1, 2,  32'h22,       32'h0,     0);
        add(1, 3, 32'h33,       1, 12, 32'hC0C0,     0, 0,  0,  0, 0, 0,  1, 3,  32'h33,       32'h0,     0);
        add(1, 4, 32'h44,       1, 12, 32'hC0C0,     0, 0,  0,  0, 0, 0,  1, 4,  32'h44,       32'h0,     0);
        add(1, 6, 32'h66,       1, 12, 32'hC0C0,     0, 0,  0,  0, 1, 0,  1, 10, 32'hA0A0,     32'h0,     1);
        add(0, 0, 32'h0,        1, 12, 32'hC0C0,     0, 0,  0,  1, 0, 0,  1, 11, 32'hB0B0,     32'h0,     1);
        add(0, 0, 32'h0,        0, 0,  32'h0,        0, 0,  0,  1, 0, 0,  1, 12, 32'hC0C0,     32'h0,     1);
        add(0, 0, 32'h0,        1, 0,  32'hFFFFFFFF, 1, 0,  0,  1, 0, 0,  0, 12, 32'hC0C0,     32'h0,     1);
        add(0, 0, 32'h0,        0, 0,  32'h0,        0, 0,  0,  1, 0, 0,  0, 12, 32'hC0C0,     32'h0,     1);
        add(0, 0, 32'h0,        0, 0,  32'h0,        1, 9,  0,  1, 0, 0,  0, 12, 32'hC0C0,     32'h200,   1);
        add(0, 0, 32'h0,        1, 9,  32'h99,       0, 0,  0,  1, 0, 0,  0, 12, 32'hC0C0,     32'h200,   1);
        add(0, 0, 32'h0,        0, 0,  32'h0,        0, 0,  0,  1, 0, 0,  1, 9,  32'h99,       32'h200,   1);
        add(0, 0, 32'h0,        0, 0,  32'h0,        1, 9,  0,  1, 0, 0,  0, 9,  32'h99,       32'h200,   1);
        add(0, 0, 32'h0,        0, 0,  32'h0,        0, 0,  9,  1, 0, 1,  0, 9,  32'h99,       32'h200,   1);

        foreach (tv[i]) begin
            @(negedge clk);
            drv(tv[i].av, tv[i].ard, tv[i].adat, tv[i].lv, tv[i].lrd,
                tv[i].ldat, tv[i].mv, tv[i].mrd, tv[i].r1, 5'd0);
            #1;
            chk($sformatf("v%0d_ready", i), 32'(bus.ld_ready), 32'(tv[i].rdy));
            chk($sformatf("v%0d_stall", i), 32'(bus.alu_stall), 32'(tv[i].st));
            chk($sformatf("v%0d_busy1", i), 32'(bus.rs1_busy), 32'(tv[i].busy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_we3", i), 32'(bus.we3), 32'(tv[i].we));
            chk($sformatf("v%0d_a3", i), 32'(bus.a3), 32'(tv[i].a3));
            chk($sformatf("v%0d_wd3", i), bus.wd3, tv[i].wd);
            chk($sformatf("v%0d_pend", i), bus.pend, tv[i].pend);
            chk($sformatf("v%0d_err", i), 32'(bus.err), 32'(tv[i].err));
        end

        // Reset asserted between edges with loads buffered and marks set.
        @(negedge clk);
        drv(1, 14, 32'hE0, 1, 13, 32'hD0, 1, 15, 0, 0);
        @(negedge clk);
        drv(1, 16, 32'hE1, 1, 17, 32'hD1, 1, 18, 0, 0);
        @(negedge clk);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("pre_arst_we3", 32'(bus.we3), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("arst");
        @(negedge clk);
        rst_n = 1'b1;

        model_reset();
        for (int c = 0; c < 600; c++) begin
            logic av;
            @(negedge clk);
            av = ($urandom_range(0, 3) != 0);
            if (m_stall() && $urandom_range(0, 7) != 0)
                av = 1'b0;
            drv(av, 5'($urandom_range(0, 31)), $urandom,
                ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)), $urandom,
                ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)),
                5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            #1;
            model_pre();
            model_step();
            @(posedge clk);
            #1;
            model_post();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
